// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, ALUOp,
// mux selects, FSM states and the per-state control word.
package mips_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned SEL_W   = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_B       = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // Raw per-state control word; the mem_ready-dependent strobes are gated in the top.
    typedef struct packed {
        logic               iord;
        logic               mem_write_req;
        logic               ir_write_req;
        logic               reg_dst;
        logic               mem_to_reg;
        logic               reg_write;
        logic               alu_src_a;
        logic [SEL_W-1:0]   alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
        logic [SEL_W-1:0]   pc_src;
        logic               pc_write;
        logic               pc_write_gated;
        logic               branch;
        logic               done;
    } ctrl_t;

    function automatic logic op_supported(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_output_decoder.sv
// Moore decode of the control FSM state into the raw datapath control word.
module mc_output_decoder
    import mips_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write_req   = 1'b1;
                ctrl.alu_src_b      = SRCB_FOUR;
                ctrl.alu_op         = ALUOP_ADD;
                ctrl.pc_src         = PCSRC_ALU;
                ctrl.pc_write       = 1'b1;
                ctrl.pc_write_gated = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.done       = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.iord          = 1'b1;
                ctrl.mem_write_req = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
                ctrl.done      = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
                ctrl.done     = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multi-cycle MIPS datapath: state register, next-state
// logic and mem_ready gating around the per-state output decoder.
module multicycle_control_fsm
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    Opcode,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [SEL_W-1:0]   ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [SEL_W-1:0]   PCSrc,
    output logic               PCEn,
    output logic               illegal_op,
    output logic               instr_done
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    logic   pc_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_ADDIEX:   state_next = S_ADDIWB;
            S_ADDIWB:   state_next = S_FETCH;
            S_JUMP:     state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    mc_output_decoder u_decoder (
        .state (state),
        .ctrl  (ctrl)
    );

    // Memory-handshake strobes fire only in the completing cycle of a wait state.
    assign pc_write   = ctrl.pc_write & (~ctrl.pc_write_gated | mem_ready);
    assign IorD       = ctrl.iord;
    assign MemWrite   = ctrl.mem_write_req & mem_ready;
    assign IRWrite    = ctrl.ir_write_req & mem_ready;
    assign RegDst     = ctrl.reg_dst;
    assign MemtoReg   = ctrl.mem_to_reg;
    assign RegWrite   = ctrl.reg_write;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ALUOp      = ctrl.alu_op;
    assign PCSrc      = ctrl.pc_src;
    assign PCEn       = pc_write | (ctrl.branch & Zero);
    assign illegal_op = (state == S_DECODE) & ~op_supported(Opcode);
    assign instr_done = ctrl.done | illegal_op | (ctrl.mem_write_req & mem_ready);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: random instruction stream with random memory stalls,
// per-instruction expectations from the latency and strobe rules.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Opcode;
    logic       Zero;
    logic       mem_ready;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCEn, illegal_op, instr_done;

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn), .illegal_op(illegal_op),
        .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cycles; int rw; int mw; int irw; int pce; int ill;
        int funct; int sub; int lastpc; int wb;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: accumulates one instruction's activity and checks it on instr_done.
    int c_cyc = 0, c_rw = 0, c_mw = 0, c_irw = 0, c_pce = 0, c_ill = 0;
    int c_funct = 0, c_sub = 0, c_lastpc = -1, c_wb = -1;
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            c_cyc++;
            c_rw    += int'(RegWrite);
            c_mw    += int'(MemWrite);
            c_irw   += int'(IRWrite);
            c_pce   += int'(PCEn);
            c_ill   += int'(illegal_op);
            c_funct += int'(ALUOp == 2'b10);
            c_sub   += int'(ALUOp == 2'b01);
            if (PCEn) c_lastpc = int'(PCSrc);
            if (RegWrite) c_wb = int'({MemtoReg, RegDst});
            if (instr_done || c_cyc > 40) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("cycles", c_cyc, e.cycles);
                    chk("regwrite_cnt", c_rw, e.rw);
                    chk("memwrite_cnt", c_mw, e.mw);
                    chk("irwrite_cnt", c_irw, e.irw);
                    chk("pcen_cnt", c_pce, e.pce);
                    chk("illegal_cnt", c_ill, e.ill);
                    chk("aluop_funct_cnt", c_funct, e.funct);
                    chk("aluop_sub_cnt", c_sub, e.sub);
                    chk("last_pcsrc", c_lastpc, e.lastpc);
                    chk("wb_sel", c_wb, e.wb);
                end
                c_cyc = 0; c_rw = 0; c_mw = 0; c_irw = 0; c_pce = 0; c_ill = 0;
                c_funct = 0; c_sub = 0; c_lastpc = -1; c_wb = -1;
            end
        end
    end

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
    endfunction

    // Drives one instruction: stall schedule chosen up front, expectation pushed first.
    task automatic run_instr(input int kind, input int f, input int m, input bit first);
        exp_t       e;
        int         base;
        int         mem_at;
        int         n;
        bit         zb;
        logic [5:0] op;
        case (kind)
            0: begin op = 6'b100011; base = 5; end
            1: begin op = 6'b101011; base = 4; end
            2: begin op = 6'b000000; base = 4; end
            3: begin op = 6'b000100; base = 3; end
            4: begin op = 6'b001000; base = 4; end
            5: begin op = 6'b000010; base = 3; end
            default: begin
                op = 6'($urandom_range(0, 63));
                while (is_legal(op)) op = 6'($urandom_range(0, 63));
                base = 2;
            end
        endcase
        if (kind > 1) m = 0;
        mem_at = f + 3;
        zb = 1'($urandom_range(0, 1));
        n  = base + f + m;
        e.cycles = n;
        e.rw     = (kind == 0 || kind == 2 || kind == 4) ? 1 : 0;
        e.mw     = (kind == 1) ? 1 : 0;
        e.irw    = 1;
        e.pce    = 1 + ((kind == 3 && zb) ? 1 : 0) + ((kind == 5) ? 1 : 0);
        e.ill    = (kind == 6) ? 1 : 0;
        e.funct  = (kind == 2) ? 1 : 0;
        e.sub    = (kind == 3) ? 1 : 0;
        e.lastpc = (kind == 5) ? 2 : ((kind == 3 && zb) ? 1 : 0);
        e.wb     = (kind == 0) ? 2 : (kind == 2) ? 1 : (kind == 4) ? 0 : -1;
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (first && i == 0) begin
                rst = 1'b0;
                mon_en = 1'b1;
            end
            Opcode = op;
            Zero = 1'($urandom_range(0, 1));
            if (kind == 3 && i == f + 2) Zero = zb;
            if (i < f)                                  mem_ready = 1'b0;
            else if (i == f)                            mem_ready = 1'b1;
            else if (kind <= 1 && i >= mem_at && i < mem_at + m) mem_ready = 1'b0;
            else if (kind <= 1 && i == mem_at + m)      mem_ready = 1'b1;
            else                                        mem_ready = 1'($urandom_range(0, 1));
            if (first && i == 0) begin
                #3;
                chk("post_reset_irwrite", int'(IRWrite), 1);
                chk("post_reset_pcen", int'(PCEn), 1);
            end
        end
    endtask

    initial begin
        int k;
        int f;
        int m;
        rst = 1'b1; Opcode = 6'b0; Zero = 1'b0; mem_ready = 1'b0;
        #1;
        chk("reset_alusrcb", int'(ALUSrcB), 1);
        chk("reset_irwrite_mr0", int'(IRWrite), 0);
        chk("reset_pcen_mr0", int'(PCEn), 0);
        chk("reset_regwrite", int'(RegWrite), 0);
        mem_ready = 1'b1;
        #1;
        chk("reset_irwrite_mr1", int'(IRWrite), 1);
        chk("reset_pcen_mr1", int'(PCEn), 1);

        // lw stalled in MEMREAD, then reset mid-instruction.
        @(posedge clk); #1; rst = 1'b0; Opcode = 6'b100011; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1; mem_ready = 1'b0;
        #3;
        chk("memread_iord", int'(IorD), 1);
        @(posedge clk); #1;
        chk("memread_hold_iord", int'(IorD), 1);
        #1; rst = 1'b1;
        #1;
        chk("midreset_iord", int'(IorD), 0);
        chk("midreset_alusrcb", int'(ALUSrcB), 1);
        chk("midreset_regwrite", int'(RegWrite), 0);
        chk("midreset_irwrite", int'(IRWrite), 0);

        for (int n = 0; n < 70; n++) begin
            k = (n < 7) ? n : int'($urandom_range(0, 6));
            f = (n == 0) ? 0 : int'($urandom_range(0, 2));
            m = int'($urandom_range(0, 2));
            run_instr(k, f, m, n == 0);
        end
        @(posedge clk); #1; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control state machine for the multi-cycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives the datapath mux selects, the register-file, IR and memory write strobes, and the 2-bit ALUOp that the existing ALU decoder expands into ALUControl. It waits on a memory-ready handshake and flags unsupported opcodes.

## Interface
Parameters: none; opcodes and encodings come from the shared package.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- Opcode  in  6  instruction bits [31:26] from the IR
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register select: 0 = rt, 1 = rd
- MemtoReg  out  1  writeback select: 0 = ALUOut, 1 = Data
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = use Funct
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC load = PCWrite | (Branch & Zero)
- illegal_op  out  1  one-cycle pulse for an unsupported opcode
- instr_done  out  1  one-cycle pulse in the final state of each instruction

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- FETCH:
  - IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite are high only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state by Opcode: 100011/101011 → MEMADR; 000000 → EXECUTE; 000100 → BRANCH; 001000 → ADDIEX; 000010 → JUMP.
  - Any other opcode → FETCH, with illegal_op=1 and instr_done=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: IorD=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Next is FETCH.
- MEMWRITE: IorD=1. MemWrite=mem_ready. Holds until mem_ready=1. On completion: instr_done=1, next is FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Next is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, instr_done=1. Next is FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Next is FETCH.
- JUMP: PCSrc=10, PCWrite=1, instr_done=1. Next is FETCH.
- Any signal not listed for a state is 0 in that state.
- All strobes (RegWrite, MemWrite, IRWrite, PCEn) are never high in two consecutive cycles for the same access.

## Timing
- State register is updated on the clk rising edge. Outputs are Moore decode of state, except the mem_ready-gated strobes.
- Reset: rst forces state to FETCH asynchronously, mid-instruction included, and no strobe fires.
- Outputs during reset equal FETCH with mem_ready=0:
  - ALUSrcB=01; all other outputs 0.
  - IRWrite and PCEn follow mem_ready.
- Latency with mem_ready held at 1, counted from entry to FETCH through the instr_done cycle:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- An undefined state encoding recovers to FETCH on the next edge.

## Structure
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - ALUOp encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - the state enum and the ALUSrcB/PCSrc select encodings.
- One sub-module, mc_output_decoder: a pure combinational map from state to the control word. The top module keeps the state register, next-state logic and mem_ready gating.
- The ALU decoder stays a separate instance in the datapath and consumes ALUOp.

## Test plan
- Reset mid-MEMREAD:
  - assert rst → state is FETCH in the same cycle, RegWrite=0.
  - deassert rst with mem_ready=1 → IRWrite=1 and PCEn=1 on the first cycle.
- lw (Opcode 100011), mem_ready=1 throughout → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 with MemtoReg=1 only in cycle 5, where instr_done=1.
- sw (101011) with mem_ready low for 2 cycles in MEMWRITE → 6 cycles total; MemWrite is high for exactly one cycle.
- beq (000100) with Zero=1 → PCEn=1 and PCSrc=01 in cycle 3.
- beq (000100) with Zero=0 → PCEn=0 in cycle 3.
- R-type (000000) → ALUOp=10 in EXECUTE, then RegDst=1 and RegWrite=1.
- Opcode 111111 → illegal_op=1 for one cycle in DECODE; no write strobe fires; FETCH on the next cycle.
